// File: rtl/spi_responder_if.sv
// spi_responder_if: transmit hold handshake and receive frame results of spi_responder.
interface spi_responder_if #(
  parameter int unsigned RX_WIDTH = 24,
  parameter int unsigned TX_WIDTH = 16
) ();
  logic [TX_WIDTH-1:0] tx_data;
  logic                tx_valid;
  logic                tx_ready;
  logic [RX_WIDTH-1:0] rx_data;
  logic                rx_valid;
  logic [5:0]          frame_len;
  logic                tx_underrun;
  logic                busy;

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, rx_data, rx_valid, frame_len, tx_underrun, busy
  );

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, rx_data, rx_valid, frame_len, tx_underrun, busy
  );
endinterface

// File: rtl/spi_responder.sv
// spi_responder: SPI target with a one-word transmit hold register and framed receive capture.
// Define SPI_RESPONDER_SYNC_EN to put a 2-flop synchronizer on SCK, SDI and CONV_CS
// (pin-to-action latency 3 clocks); otherwise the pins must be synchronous to S_AXI_ACLK (latency 1).
module spi_responder #(
  parameter int unsigned RX_WIDTH = 24,
  parameter int unsigned TX_WIDTH = 16
) (
  input  logic           S_AXI_ACLK,
  input  logic           S_AXI_ARESET,
  input  logic           SCK,
  input  logic           SDI,
  input  logic           CONV_CS,
  output logic           SDO,
  spi_responder_if.slave bus
);
  localparam int unsigned CNT_W = 6;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t state, state_n;

  logic sck_s, sdi_s, cs_s;
  logic sck_d, cs_d;
  logic sck_rise, sck_fall, cs_fall, cs_rise;

  logic [TX_WIDTH-1:0] tx_sh, tx_sh_n;
  logic [RX_WIDTH-1:0] rx_sh, rx_sh_n;
  logic [CNT_W-1:0]    cnt, cnt_n;
  logic [TX_WIDTH-1:0] hold, hold_n;
  logic                hold_empty, hold_empty_n;
  logic                sdo_n;
  logic [RX_WIDTH-1:0] rx_data_n;
  logic [CNT_W-1:0]    frame_len_n;
  logic                underrun_n;

`ifdef SPI_RESPONDER_SYNC_EN
  logic [1:0] sck_m, sdi_m, cs_m;

  // Two-flop synchronizer per input pin
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      sck_m <= '0;
      sdi_m <= '0;
      cs_m  <= '0;
    end else begin
      sck_m <= {sck_m[0], SCK};
      sdi_m <= {sdi_m[0], SDI};
      cs_m  <= {cs_m[0], CONV_CS};
    end
  end

  assign sck_s = sck_m[1];
  assign sdi_s = sdi_m[1];
  assign cs_s  = cs_m[1];
`else
  assign sck_s = SCK;
  assign sdi_s = SDI;
  assign cs_s  = CONV_CS;
`endif

  // Edge-detect registers; resetting to 0 forces CONV_CS to be seen high before a frame
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      sck_d <= 1'b0;
      cs_d  <= 1'b0;
    end else begin
      sck_d <= sck_s;
      cs_d  <= cs_s;
    end
  end

  assign sck_rise = sck_s & ~sck_d;
  assign sck_fall = ~sck_s & sck_d;
  assign cs_fall  = ~cs_s & cs_d;
  assign cs_rise  = cs_s & ~cs_d;

  // State register
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) state <= IDLE;
    else              state <= state_n;
  end

  // Next-state and datapath next values
  always_comb begin
    state_n      = state;
    tx_sh_n      = tx_sh;
    rx_sh_n      = rx_sh;
    cnt_n        = cnt;
    sdo_n        = SDO;
    hold_n       = hold;
    hold_empty_n = hold_empty;
    rx_data_n    = bus.rx_data;
    frame_len_n  = bus.frame_len;
    underrun_n   = 1'b0;

    if (bus.tx_valid && hold_empty) begin
      hold_n       = bus.tx_data;
      hold_empty_n = 1'b0;
    end

    unique case (state)
      IDLE: begin
        sdo_n = 1'b0;
        if (cs_fall) begin
          state_n = SHIFT;
          cnt_n   = '0;
          rx_sh_n = '0;
          if (!hold_empty) begin
            tx_sh_n      = hold;
            hold_empty_n = 1'b1;
            sdo_n        = hold[TX_WIDTH-1];
          end else begin
            tx_sh_n    = '0;
            underrun_n = 1'b1;
          end
        end
      end
      SHIFT: begin
        if (cs_rise) begin
          state_n     = DONE;
          rx_data_n   = rx_sh;
          frame_len_n = cnt;
          sdo_n       = 1'b0;
        end else if (sck_rise) begin
          rx_sh_n = {rx_sh[RX_WIDTH-2:0], sdi_s};
          if (cnt != CNT_MAX) cnt_n = cnt + CNT_W'(1);
        end else if (sck_fall) begin
          tx_sh_n = {tx_sh[TX_WIDTH-2:0], 1'b0};
          sdo_n   = tx_sh[TX_WIDTH-2];
        end
      end
      DONE: begin
        state_n = IDLE;
        sdo_n   = 1'b0;
      end
      default: state_n = IDLE;
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      tx_sh           <= '0;
      rx_sh           <= '0;
      cnt             <= '0;
      hold            <= '0;
      hold_empty      <= 1'b1;
      SDO             <= 1'b0;
      bus.rx_data     <= '0;
      bus.frame_len   <= '0;
      bus.rx_valid    <= 1'b0;
      bus.tx_underrun <= 1'b0;
      bus.busy        <= 1'b0;
    end else begin
      tx_sh           <= tx_sh_n;
      rx_sh           <= rx_sh_n;
      cnt             <= cnt_n;
      hold            <= hold_n;
      hold_empty      <= hold_empty_n;
      SDO             <= sdo_n;
      bus.rx_data     <= rx_data_n;
      bus.frame_len   <= frame_len_n;
      bus.rx_valid    <= (state_n == DONE);
      bus.tx_underrun <= underrun_n;
      bus.busy        <= (state_n != IDLE);
    end
  end

  assign bus.tx_ready = hold_empty;
endmodule

// File: tb/tb_spi_responder.sv
// tb_spi_responder: directed frames against a transaction-level model of spi_responder.
module tb_spi_responder;
  localparam int unsigned RX_WIDTH = 24;
  localparam int unsigned TX_WIDTH = 16;
`ifdef SPI_RESPONDER_SYNC_EN
  localparam int L = 3;
`else
  localparam int L = 1;
`endif
  localparam int HALF = L + 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sck = 1'b0;
  logic sdi = 1'b0;
  logic cs  = 1'b1;
  logic sdo;

  spi_responder_if #(.RX_WIDTH(RX_WIDTH), .TX_WIDTH(TX_WIDTH)) bus ();

  spi_responder #(.RX_WIDTH(RX_WIDTH), .TX_WIDTH(TX_WIDTH)) dut (
    .S_AXI_ACLK  (clk),
    .S_AXI_ARESET(rst),
    .SCK         (sck),
    .SDI         (sdi),
    .CONV_CS     (cs),
    .SDO         (sdo),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Transaction-level model state
  logic [RX_WIDTH-1:0] exp_rx_q[$];
  logic [5:0]          exp_len_q[$];
  logic [RX_WIDTH-1:0] last_rx = '0;
  logic [5:0]          last_len = '0;
  bit                  hold_full = 1'b0;
  logic [TX_WIDTH-1:0] hold_word = '0;
  bit                  exp_tx_ready = 1'b1;
  bit                  frame_ok = 1'b0;
  int                  underrun_pending = 0;
  logic [TX_WIDTH-1:0] frame_word = '0;
  bit                  in_frame = 1'b0;
  int                  bit_idx = 0;
  logic [63:0]         sdo_cap = '0;
  int                  cs_stable = 0;
  logic                cs_prev = 1'b1;
  logic                sck_prev = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic exp_bit(input int i);
    if (i < TX_WIDTH) return frame_word[TX_WIDTH-1-i];
    return 1'b0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Per-cycle comparison against the model
  initial begin
    forever begin
      @(negedge clk);
      if (cs !== cs_prev) cs_stable = 1;
      else cs_stable++;
      cs_prev = cs;
      if (!rst) begin
        check("tx_ready", bus.tx_ready, exp_tx_ready);
        if (bus.rx_valid) begin
          check("rx_valid_expected", bus.rx_valid, exp_rx_q.size() > 0);
          if (exp_rx_q.size() > 0) begin
            last_rx  = exp_rx_q.pop_front();
            last_len = exp_len_q.pop_front();
          end
        end
        check("rx_data", bus.rx_data, last_rx);
        check("frame_len", bus.frame_len, last_len);
        if (bus.tx_underrun) begin
          check("tx_underrun_expected", bus.tx_underrun, underrun_pending > 0);
          if (underrun_pending > 0) underrun_pending--;
        end
        if (cs_stable >= L + 2) begin
          check("busy", bus.busy, (cs == 1'b0) && frame_ok);
          if (cs) check("sdo_idle", sdo, 1'b0);
        end
        if (in_frame && sck && !sck_prev) begin
          check("sdo_bit", sdo, exp_bit(bit_idx));
          sdo_cap = {sdo_cap[62:0], sdo};
          bit_idx++;
        end
      end
      sck_prev = sck;
    end
  end

  task automatic load(input logic [TX_WIDTH-1:0] w);
    bus.tx_data  = w;
    bus.tx_valid = 1'b1;
    tick();
    bus.tx_valid = 1'b0;
    hold_full    = 1'b1;
    hold_word    = w;
    exp_tx_ready = 1'b0;
  endtask

  // CS fall; optionally offer a tx word in the very cycle the fall is acted on
  task automatic frame_start(input bit load_same, input logic [TX_WIDTH-1:0] w);
    cs = 1'b0;
    repeat (L - 1) tick();
    if (load_same) begin
      bus.tx_data  = w;
      bus.tx_valid = 1'b1;
    end
    tick();
    bus.tx_valid = 1'b0;
    frame_word   = hold_full ? hold_word : '0;
    if (!hold_full) underrun_pending++;
    hold_full = 1'b0;
    if (load_same) begin
      hold_full = 1'b1;
      hold_word = w;
    end
    exp_tx_ready = !hold_full;
    frame_ok     = 1'b1;
    in_frame     = 1'b1;
    bit_idx      = 0;
    sdo_cap      = '0;
    repeat (2) tick();
  endtask

  task automatic send_bits(input logic [63:0] val, input int n, input int count);
    for (int i = n - 1; i >= n - count; i--) begin
      sdi = val[i];
      repeat (HALF) tick();
      sck = 1'b1;
      repeat (HALF) tick();
      sck = 1'b0;
    end
  endtask

  task automatic frame_end(input logic [63:0] val, input int n);
    int k;
    repeat (HALF) tick();
    k = (n < RX_WIDTH) ? n : RX_WIDTH;
    exp_rx_q.push_back(RX_WIDTH'(val & ((64'd1 << k) - 64'd1)));
    exp_len_q.push_back((n > 63) ? 6'd63 : 6'(n));
    cs       = 1'b1;
    in_frame = 1'b0;
    frame_ok = 1'b0;
    repeat (L + 3) tick();
    check("rx_valid_seen", exp_rx_q.size(), 0);
    check("underrun_seen", underrun_pending, 0);
  endtask

  task automatic frame(input bit load_same, input logic [TX_WIDTH-1:0] w,
                       input logic [63:0] val, input int n);
    frame_start(load_same, w);
    send_bits(val, n, n);
    frame_end(val, n);
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_frame = 1'b0;
    frame_ok = 1'b0;
    repeat (2) tick();
    hold_full        = 1'b0;
    exp_tx_ready     = 1'b1;
    last_rx          = '0;
    last_len         = '0;
    underrun_pending = 0;
    exp_rx_q.delete();
    exp_len_q.delete();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    bus.tx_data  = '0;
    bus.tx_valid = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Reset state
    check("reset_busy", bus.busy, 1'b0);
    check("reset_tx_ready", bus.tx_ready, 1'b1);
    check("reset_rx_valid", bus.rx_valid, 1'b0);
    check("reset_underrun", bus.tx_underrun, 1'b0);
    check("reset_sdo", sdo, 1'b0);
    check("reset_rx_data", bus.rx_data, 0);
    check("reset_frame_len", bus.frame_len, 0);
    repeat (4) tick();

    // Loaded word, full 24-bit frame
    load(16'hA5C3);
    check("load_tx_ready", bus.tx_ready, 1'b0);
    frame(1'b0, '0, 64'h3FF123, 24);
    check("f1_rx_data", bus.rx_data, 24'h3FF123);
    check("f1_frame_len", bus.frame_len, 24);
    check("f1_sdo_stream", sdo_cap, 64'hA5C300);

    // Underrun frame: SDO all zero
    frame(1'b0, '0, 64'h5A, 8);
    check("f2_sdo_stream", sdo_cap, 0);
    check("f2_tx_ready", bus.tx_ready, 1'b1);

    // Short frame right-aligned
    frame(1'b0, '0, 64'hBEEF, 16);
    check("f3_rx_data", bus.rx_data, 24'h00BEEF);
    check("f3_frame_len", bus.frame_len, 16);

    // Long frame keeps last 24 bits
    load(16'h1234);
    frame(1'b0, '0, 64'h15A5A5A5, 30);
    check("f4_rx_data", bus.rx_data, 24'hA5A5A5);
    check("f4_frame_len", bus.frame_len, 30);
    check("f4_sdo_stream", sdo_cap, 64'h48D0000);

    // tx_valid in the underrun cycle fills the hold for the next frame
    frame(1'b1, 16'hC0DE, 64'h81, 8);
    check("f5_tx_ready", bus.tx_ready, 1'b0);
    frame(1'b0, '0, 64'h0, 16);
    check("f6_sdo_stream", sdo_cap, 64'hC0DE);

    // Reset after 10 SCK edges, with a word pending in the hold register
    frame_start(1'b0, '0);
    send_bits(64'hABCDEF, 24, 5);
    load(16'h7777);
    do_reset();
    check("abort_busy", bus.busy, 1'b0);
    check("abort_sdo", sdo, 1'b0);
    check("abort_rx_valid", bus.rx_valid, 1'b0);
    check("abort_tx_ready", bus.tx_ready, 1'b1);
    check("abort_rx_data", bus.rx_data, 0);
    repeat (L + 4) tick();
    cs = 1'b1;
    repeat (L + 4) tick();
    frame(1'b0, '0, 64'h0F0F0F, 24);
    check("f7_rx_data", bus.rx_data, 24'h0F0F0F);
    check("f7_frame_len", bus.frame_len, 24);

    // SCK activity with CS high is ignored
    for (int i = 0; i < 8; i++) begin
      sdi = i[0];
      sck = ~sck;
      repeat (HALF) tick();
    end
    repeat (L + 3) tick();
    check("idle_rx_data", bus.rx_data, 24'h0F0F0F);
    check("idle_frame_len", bus.frame_len, 24);
    check("idle_busy", bus.busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/spi_responder.md
SPI_RESPONDER -- requirements
Module: spi_responder

Interface
REQ-001 SHALL have parameter RX_WIDTH, default 24, receive shift-register and rx_data width (2..32).
REQ-002 SHALL have parameter TX_WIDTH, default 16, transmit word width (2..32).
REQ-003 SHALL use one clock and a synchronous, active-high reset.
REQ-004 Port list, clock and reset first:
- S_AXI_ACLK  in  1  system clock
- S_AXI_ARESET  in  1  synchronous reset, active-high
- SCK  in  1  SPI shift clock from the initiator
- SDI  in  1  serial data from the initiator
- CONV_CS  in  1  frame select, active-low
- SDO  out  1  serial data to the initiator
- tx_data  in  TX_WIDTH  next word to transmit
- tx_valid  in  1  tx_data valid
- tx_ready  out  1  hold register empty
- rx_data  out  RX_WIDTH  last received frame
- rx_valid  out  1  one-cycle frame-done pulse
- frame_len  out  6  SCK rising edges in the last frame
- tx_underrun  out  1  one-cycle pulse: frame started with hold empty
- busy  out  1  frame in progress

Function
REQ-005 SHALL sample SCK, SDI and CONV_CS through the input stage defined in REQ-020, then one edge-detect register per signal; pin-to-action latency L is 3 clocks with the synchronizer and 1 clock without it.
REQ-006 SHALL implement states IDLE, SHIFT and DONE; busy = (state != IDLE).
REQ-007 IDLE -> SHIFT on a detected CONV_CS falling edge: load the TX shifter from the hold register (or all zeros if the hold register is empty), clear the bit count and rx shifter, and drive SDO = shifter MSB.
REQ-008 SHIFT, SCK rising edge: rx shifter <= {rx[RX_WIDTH-2:0], SDI}; bit count increments and saturates at 63.
REQ-009 SHIFT, SCK falling edge: TX shifter shifts left with zero fill; SDO = new MSB. Bits beyond TX_WIDTH are 0.
REQ-010 SHIFT -> DONE on a detected CONV_CS rising edge: rx_data <= rx shifter, frame_len <= bit count, rx_valid = 1 for exactly the DONE cycle; DONE -> IDLE unconditionally on the next clock.
REQ-011 Frames longer than RX_WIDTH SHALL keep the last RX_WIDTH bits received. Shorter frames SHALL be right-aligned with zero-filled upper bits.
REQ-012 SDO SHALL be 0 in IDLE and DONE. SCK/SDI edges outside SHIFT SHALL be ignored.
REQ-013 With SCK high and low for at least L+1 clocks each, every SDO bit SHALL be stable before the following SCK rising edge and held through it.
REQ-014 tx_ready = hold empty; tx_valid && tx_ready SHALL capture tx_data and mark the hold register full. The hold register empties when it is loaded into the shifter.
REQ-015 If the hold register is empty at CS fall, tx_underrun SHALL pulse for one cycle, and a tx_valid in that same cycle SHALL fill the hold register for the next frame.
REQ-016 rx_valid has no backpressure. rx_data and frame_len SHALL hold their values until the next DONE.

Reset
REQ-017 On reset: state IDLE, SDO 0, tx_ready 1, rx_valid 0, tx_underrun 0, busy 0, rx_data 0, frame_len 0, hold register empty, all shifters and counters 0.
REQ-018 Synchronizer and edge registers SHALL reset to 0, so CONV_CS must be seen high after reset before a frame can start.
REQ-019 Reset mid-frame SHALL abort the frame with no rx_valid and SHALL discard any word in the hold register.

Configuration
REQ-020 Macro SPI_RESPONDER_SYNC_EN: when defined, each input passes through a 2-flop synchronizer (L = 3); when undefined, inputs feed the edge registers directly (L = 1, inputs must be synchronous to S_AXI_ACLK). All other behaviour is identical.

Verification
REQ-021 Load tx 0xA5C3; send a 24-bit frame with SDI 0x3FF123, SCK 3 clocks high / 3 clocks low -> rx_data 0x3FF123, frame_len 24, one rx_valid pulse, SDO = A5C3 MSB-first then 8 zeros.
REQ-022 Send a frame with no tx loaded -> tx_underrun pulse at CS fall, SDO all 0, tx_ready stays 1.
REQ-023 Send a 16-bit frame with SDI 0xBEEF -> rx_data 0x00BEEF, frame_len 16.
REQ-024 Send a 30-bit frame -> rx_data = the last 24 bits sent, frame_len 30.
REQ-025 Assert reset after 10 SCK edges of a frame -> no rx_valid, busy 0, SDO 0; after CS goes high then low, the next frame completes normally.
REQ-026 Toggle SCK 8 times with CONV_CS high -> rx_valid never asserts, busy 0, outputs unchanged.
